// File: rtl/shift_arb_pkg.sv
// ---------------------------------------------------------------------------
// shift_arb_pkg
// Shared types and helpers for the shift_unit_arbiter block.
//   state_t        : arbiter FSM states (IDLE, SHIFT, DONE)
//   DEFAULT_WIDTH  : default word width (MemoryElementWidth)
//   clamp_amount() : min(amount, width); shifting by >= width yields zero,
//                    so longer shifts never need more than width iterations
// Optional feature macro used by the block: SHIFT_OVERFLOW_EN.
// ---------------------------------------------------------------------------
package shift_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 12;

    // The amount is unsigned; it is zero-extended to 32 bits, so WIDTH is
    // expected to stay at or below 32.
    function automatic int clamp_amount(input logic [31:0] amount, input int width);
        if (amount > 32'(width))
            return width;
        else
            return int'(amount);
    endfunction

endpackage

// File: rtl/shift_unit_arbiter_if.sv
// ---------------------------------------------------------------------------
// shift_unit_arbiter_if
// Request/response bundle between NREQ program engines, the shared shifter
// and the result consumer.
//   req_valid  [NREQ]        request valid, one per requester
//   req_ready  [NREQ]        accept, at most one bit high
//   req_value  [NREQ][WIDTH] operand, slice i belongs to requester i
//   req_amount [NREQ][WIDTH] unsigned shift amount
//   rsp_valid / rsp_ready    result handshake
//   rsp_id     [IDW]         owner of the result
//   rsp_value  [WIDTH]       shifted result
//   busy                     block not idle
//   rsp_overflow             only with SHIFT_OVERFLOW_EN: a set bit was
//                            shifted out of the word
// Modports: master = requesters + consumer, slave = the arbiter.
// ---------------------------------------------------------------------------
interface shift_unit_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 12
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0]            req_ready;
    logic [NREQ-1:0][WIDTH-1:0] req_value;
    logic [NREQ-1:0][WIDTH-1:0] req_amount;
    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [IDW-1:0]             rsp_id;
    logic [WIDTH-1:0]           rsp_value;
    logic                       busy;
`ifdef SHIFT_OVERFLOW_EN
    logic                       rsp_overflow;

    modport master (
        output req_valid, req_value, req_amount, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_value, busy, rsp_overflow
    );
    modport slave (
        input  req_valid, req_value, req_amount, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_value, busy, rsp_overflow
    );
`else
    modport master (
        output req_valid, req_value, req_amount, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_value, busy
    );
    modport slave (
        input  req_valid, req_value, req_amount, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_value, busy
    );
`endif
endinterface

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin grant. Searches from i_last_grant+1 with
// wrap-around for the first asserted request. The last-grant pointer itself
// lives in the parent so it only moves on a real accept.
//   i_req        [NREQ]  request vector
//   i_last_grant [IDW]   most recently granted index
//   i_enable             grant allowed this cycle
//   o_grant      [NREQ]  one-hot grant (all zero when disabled / no request)
//   o_grant_idx  [IDW]   index of the granted bit (0 when no grant)
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         i_req,
    input  logic [$clog2(NREQ)-1:0] i_last_grant,
    input  logic                    i_enable,
    output logic [NREQ-1:0]         o_grant,
    output logic [$clog2(NREQ)-1:0] o_grant_idx
);
    localparam int IDW = $clog2(NREQ);

    logic [IDW-1:0] w_idx;

    // Walk the candidates from farthest to nearest; the last hit wins, which
    // leaves the nearest requester after last_grant holding the grant.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_idx       = '0;
        if (i_enable) begin
            for (int k = NREQ; k >= 1; k--) begin
                w_idx = IDW'((int'(i_last_grant) + k) % NREQ);
                if (i_req[w_idx]) begin
                    o_grant        = '0;
                    o_grant[w_idx] = 1'b1;
                    o_grant_idx    = w_idx;
                end
            end
        end
    end

endmodule

// File: rtl/shift_unit_arbiter.sv
// ---------------------------------------------------------------------------
// shift_unit_arbiter
// One iterative left shifter shared by NREQ requesters. A round-robin grant
// picks a requester in IDLE, the operand is shifted one bit per cycle in
// SHIFT, and the tagged result is held in DONE until the consumer takes it.
// One operation in flight at a time.
//   clock   rising-edge clock
//   reset   asynchronous active-low reset
//   bus     shift_unit_arbiter_if.slave (requests, response, busy)
// Optional: define SHIFT_OVERFLOW_EN to add bus.rsp_overflow, a sticky flag
// that reports a 1 bit shifted out of the word during the operation.
// ---------------------------------------------------------------------------
module shift_unit_arbiter
    import shift_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clock,
    input  logic                 reset,
    shift_unit_arbiter_if.slave  bus
);
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(WIDTH + 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic [IDW-1:0]   r_id;
    logic [IDW-1:0]   r_last_grant;

    logic             w_idle;
    logic [NREQ-1:0]  w_grant;
    logic [IDW-1:0]   w_grant_idx;
    logic             w_accept;
    logic [CW-1:0]    w_cnt_init;

    assign w_idle = (r_state == IDLE);

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .i_req        (bus.req_valid),
        .i_last_grant (r_last_grant),
        .i_enable     (w_idle),
        .o_grant      (w_grant),
        .o_grant_idx  (w_grant_idx)
    );

    // The grant only covers valid requesters, so a grant is an accept.
    assign w_accept   = |(bus.req_valid & w_grant);
    assign w_cnt_init = CW'(clamp_amount(32'(bus.req_amount[w_grant_idx]), WIDTH));

    // ---------------- state register ----------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // ---------------- next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_state_nxt = (w_cnt_init != '0) ? SHIFT : DONE;
            SHIFT:   if (r_cnt == CW'(1)) w_state_nxt = DONE;
            DONE:    if (bus.rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_acc        <= '0;
            r_cnt        <= '0;
            r_id         <= '0;
            r_last_grant <= IDW'(NREQ - 1);
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_acc        <= bus.req_value[w_grant_idx];
                        r_cnt        <= w_cnt_init;
                        r_id         <= w_grant_idx;
                        r_last_grant <= w_grant_idx;
                    end
                end
                SHIFT: begin
                    r_acc <= r_acc << 1;
                    r_cnt <= r_cnt - CW'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef SHIFT_OVERFLOW_EN
    logic r_ovf;

    // Top bit before each shift step is the bit about to be lost.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_ovf <= 1'b0;
        else if (w_idle && w_accept)
            r_ovf <= 1'b0;
        else if (r_state == SHIFT && r_acc[WIDTH-1])
            r_ovf <= 1'b1;
    end

    assign bus.rsp_overflow = (r_state == DONE) & r_ovf;
`endif

    // ---------------- outputs ----------------
    assign bus.req_ready = w_grant;
    assign bus.rsp_valid = (r_state == DONE);
    assign bus.rsp_value = (r_state == DONE) ? r_acc : '0;
    assign bus.rsp_id    = r_id;
    assign bus.busy      = ~w_idle;

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// ---------------------------------------------------------------------------
// tb_shift_unit_arbiter
// Directed stimulus against shift_unit_arbiter. A transaction-level model
// predicts grants, response timing and results from the arithmetic rules;
// one negedge process compares the DUT against it every cycle. Directed
// sections add literal expectations on latency, values and order.
// ---------------------------------------------------------------------------
module tb_shift_unit_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 12;

    logic clock = 1'b0;
    logic reset = 1'b0;

    shift_unit_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) u_if ();

    shift_unit_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (u_if)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out (cycle %0d)", nm, cyc);
    endtask

    // ---------------- transaction model ----------------
    typedef struct {
        int id;
        int val;
        bit ovf;
    } rsp_t;

    rsp_t   log_q[$];
    bit     m_busy = 0;
    int     m_last = NREQ - 1;
    int     m_id   = 0;
    int     m_due  = 0;
    longint m_val  = 0;
    bit     m_ovf  = 0;

    logic [NREQ-1:0] e_rdy;
    int     e_g;
    bit     e_v;
    int     e_k;
    longint e_op;

    always @(negedge clock) begin
        if (!reset) begin
            m_busy = 0;
            m_last = NREQ - 1;
        end else begin
            e_rdy = '0;
            e_g   = -1;
            if (!m_busy)
                for (int s = 1; s <= NREQ; s++)
                    if (e_g < 0 && u_if.req_valid[(m_last + s) % NREQ]) begin
                        e_g = (m_last + s) % NREQ;
                        e_rdy[e_g] = 1'b1;
                    end
            chk("req_ready", u_if.req_ready, e_rdy);
            chk("ready_at_most_one", $countones(u_if.req_ready) <= 1, 1);
            chk("busy", u_if.busy, m_busy);
            e_v = m_busy && (cyc >= m_due);
            chk("rsp_valid", u_if.rsp_valid, e_v);
            if (e_v) begin
                chk("rsp_value", u_if.rsp_value, m_val);
                chk("rsp_id", u_if.rsp_id, m_id);
`ifdef SHIFT_OVERFLOW_EN
                chk("rsp_overflow", u_if.rsp_overflow, m_ovf);
`endif
            end
            if (e_v && u_if.rsp_ready) begin
                log_q.push_back('{id: m_id, val: int'(m_val), ovf: m_ovf});
                m_busy = 0;
            end else if (!m_busy && e_g >= 0) begin
                e_op   = longint'(u_if.req_value[e_g]);
                e_k    = (int'(u_if.req_amount[e_g]) > WIDTH) ? WIDTH : int'(u_if.req_amount[e_g]);
                m_val  = (e_op << e_k) & ((64'd1 << WIDTH) - 1);
                m_ovf  = (e_k > 0) && ((e_op >> (WIDTH - e_k)) != 0);
                m_id   = e_g;
                m_last = e_g;
                m_due  = cyc + 1 + e_k;
                m_busy = 1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input int id, input int val, input int amt, output int acc_cyc);
        int n;
        n = 0;
        @(posedge clock); #1;
        u_if.req_valid[id]  = 1'b1;
        u_if.req_value[id]  = WIDTH'(val);
        u_if.req_amount[id] = WIDTH'(amt);
        do begin
            @(negedge clock);
            n++;
        end while (!u_if.req_ready[id] && n < 200);
        if (!u_if.req_ready[id]) timeout("accept");
        acc_cyc = cyc;
        @(posedge clock); #1;
        u_if.req_valid[id] = 1'b0;
    endtask

    task automatic wait_rsp(output int rsp_cyc);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!u_if.rsp_valid && n < 200);
        if (!u_if.rsp_valid) timeout("rsp_valid");
        rsp_cyc = cyc;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (u_if.busy && n < 200);
        if (u_if.busy) timeout("idle");
    endtask

    task automatic do_reset();
        @(negedge clock); #2;
        reset = 1'b0;
        @(negedge clock);
        @(negedge clock); #2;
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- directed tests ----------------
    initial begin
        int a, r, n;
        int exp_id[5];
        int exp_val[5];
        exp_id  = '{0, 1, 2, 3, 0};
        exp_val = '{2, 4, 8, 16, 2};

        u_if.req_valid  = '0;
        u_if.req_value  = '0;
        u_if.req_amount = '0;
        u_if.rsp_ready  = 1'b0;

        // reset state
        repeat (2) @(negedge clock);
        chk("rst_rsp_valid", u_if.rsp_valid, 0);
        chk("rst_busy", u_if.busy, 0);
        chk("rst_rsp_id", u_if.rsp_id, 0);
        chk("rst_rsp_value", u_if.rsp_value, 0);
        chk("rst_req_ready", u_if.req_ready, 0);
`ifdef SHIFT_OVERFLOW_EN
        chk("rst_rsp_overflow", u_if.rsp_overflow, 0);
`endif
        #2 reset = 1'b1;

        // 1 << 1
        u_if.rsp_ready = 1'b1;
        issue(0, 1, 1, a);
        wait_rsp(r);
        chk("t1_latency", r - a, 2);
        chk("t1_value", u_if.rsp_value, 12'h002);
        chk("t1_id", u_if.rsp_id, 0);
        wait_idle();

        // amount 0 passes the operand through
        issue(0, 'h5A5, 0, a);
        wait_rsp(r);
        chk("t2_latency", r - a, 1);
        chk("t2_value", u_if.rsp_value, 12'h5A5);
        wait_idle();

        // huge amount clamps to WIDTH, result zero
        issue(2, 'hFFF, 4095, a);
        wait_rsp(r);
        chk("t3_latency", r - a, 13);
        chk("t3_value", u_if.rsp_value, 0);
        chk("t3_id", u_if.rsp_id, 2);
`ifdef SHIFT_OVERFLOW_EN
        chk("t3_overflow", u_if.rsp_overflow, 1);
`endif
        wait_idle();

        // continuous demand from all requesters
        do_reset();
        log_q.delete();
        @(posedge clock); #1;
        for (int i = 0; i < NREQ; i++) begin
            u_if.req_valid[i]  = 1'b1;
            u_if.req_value[i]  = WIDTH'(1);
            u_if.req_amount[i] = WIDTH'(i + 1);
        end
        n = 0;
        while (log_q.size() < 5 && n < 300) begin
            @(negedge clock);
            n++;
        end
        @(posedge clock); #1;
        u_if.req_valid = '0;
        wait_idle();
        if (log_q.size() < 5) timeout("t4_responses");
        else
            for (int i = 0; i < 5; i++) begin
                chk($sformatf("t4_id%0d", i), log_q[i].id, exp_id[i]);
                chk($sformatf("t4_val%0d", i), log_q[i].val, exp_val[i]);
            end

        // response back-pressure
        log_q.delete();
        u_if.rsp_ready = 1'b0;
        issue(1, 3, 2, a);
        wait_rsp(r);
        chk("t5_latency", r - a, 3);
        @(posedge clock); #1;
        u_if.req_valid[0]  = 1'b1;
        u_if.req_value[0]  = WIDTH'(5);
        u_if.req_amount[0] = WIDTH'(3);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clock);
            chk("t5_hold_valid", u_if.rsp_valid, 1);
            chk("t5_hold_value", u_if.rsp_value, 12);
            chk("t5_hold_id", u_if.rsp_id, 1);
        end
        @(posedge clock); #1;
        u_if.rsp_ready = 1'b1;
        @(negedge clock);
        chk("t5_hs_busy", u_if.busy, 1);
        chk("t5_hs_no_accept", u_if.req_ready, 0);
        @(negedge clock);
        chk("t5_idle_after_hs", u_if.busy, 0);
        chk("t5_next_grant", u_if.req_ready, 4'b0001);
        @(posedge clock); #1;
        u_if.req_valid[0] = 1'b0;
        wait_idle();
        chk("t5_count", log_q.size(), 2);
        if (log_q.size() == 2) begin
            chk("t5_second_id", log_q[1].id, 0);
            chk("t5_second_val", log_q[1].val, 40);
        end

        // reset in the middle of an operation
        do_reset();
        issue(3, 1, 8, a);
        repeat (4) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        chk("t6_rst_rsp_valid", u_if.rsp_valid, 0);
        chk("t6_rst_busy", u_if.busy, 0);
        chk("t6_rst_rsp_id", u_if.rsp_id, 0);
        chk("t6_rst_rsp_value", u_if.rsp_value, 0);
        chk("t6_rst_req_ready", u_if.req_ready, 0);
        @(negedge clock); #2;
        reset = 1'b1;
        log_q.delete();
        @(posedge clock); #1;
        u_if.req_valid[0]  = 1'b1;
        u_if.req_value[0]  = WIDTH'(7);
        u_if.req_amount[0] = WIDTH'(1);
        u_if.req_valid[3]  = 1'b1;
        u_if.req_value[3]  = WIDTH'(9);
        u_if.req_amount[3] = WIDTH'(2);
        @(negedge clock);
        chk("t6_first_grant", u_if.req_ready, 4'b0001);
        @(posedge clock); #1;
        u_if.req_valid[0] = 1'b0;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!u_if.req_ready[3] && n < 200);
        if (!u_if.req_ready[3]) timeout("t6_grant3");
        @(posedge clock); #1;
        u_if.req_valid[3] = 1'b0;
        wait_idle();
        chk("t6_count", log_q.size(), 2);
        if (log_q.size() == 2) begin
            chk("t6_id0", log_q[0].id, 0);
            chk("t6_val0", log_q[0].val, 14);
            chk("t6_id1", log_q[1].id, 3);
            chk("t6_val1", log_q[1].val, 36);
        end

        repeat (2) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_unit_arbiter.md
Name: shift_unit_arbiter

Overview:
- Shares one iterative left-shifter among NREQ program engines, each of which would otherwise carry its own shiftLeft datapath.
- Round-robin arbitration and valid/ready handshakes on both sides; one operation is in flight at a time.
- The result is returned tagged with the requester id.
- Operand semantics match the instruction set: value << amount on MemoryElementWidth-bit words, where the amount is a full-width word.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 12, word width; matches MemoryElementWidth
- IDW, $clog2(NREQ), requester id width (derived localparam)

Ports:
- clock  in  1  single clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; at most one bit high
- req_value  in  NREQ*WIDTH  packed operands; slice i belongs to requester i
- req_amount  in  NREQ*WIDTH  packed shift amounts, unsigned
- rsp_valid  out  1  result valid
- rsp_ready  in  1  result consumer ready
- rsp_id  out  IDW  index of the requester that owns the result
- rsp_value  out  WIDTH  shifted result
- busy  out  1  high in every state other than IDLE

Behaviour:
- Reset values: state=IDLE; req_ready=0; rsp_valid=0; rsp_id=0; rsp_value=0; acc=0; cnt=0; busy=0; last_grant=NREQ-1, so requester 0 has first priority.
- A reset asserted mid-operation abandons the operation; no response is produced.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - Grant g is the first i with req_valid[i], searching from last_grant+1 with wrap-around.
  - req_ready[g] is driven combinationally in IDLE only. All other req_ready bits are 0, and all are 0 outside IDLE.
  - Accept is the cycle in which req_valid[g] && req_ready[g]. On accept: acc=value[g]; cnt=min(amount[g], WIDTH); rsp_id=g; last_grant=g.
  - Next state is SHIFT if cnt>0, else DONE.
  - last_grant changes only on accept.
- SHIFT: each cycle acc<=acc<<1 and cnt<=cnt-1. When cnt==1, the next state is DONE.
- DONE:
  - rsp_valid=1 and rsp_value=acc.
  - rsp_value, rsp_id and rsp_valid hold stable until rsp_ready is high.
  - On the handshake the block returns to IDLE. The next accept can occur in the cycle after the response handshake, never in the same cycle.
- Latency: rsp_valid rises 1+min(amount,WIDTH) cycles after the accept edge.
  - amount=0: 1 cycle.
  - amount>=WIDTH: WIDTH+1 cycles, result 0.
- Arithmetic: logical shift with zero fill. Bits shifted past bit WIDTH-1 are discarded. The amount is unsigned and never sign-interpreted.
- Requester rules:
  - A requester keeps req_valid and its operands stable until accepted.
  - A requester that drops req_valid before its accept loses its turn, with no side effect.
  - Operands are sampled only on the accept cycle; later changes do not affect an operation in flight.
- Simultaneous requests: exactly one grant per accept. Under continuous demand from every requester, the grant order is 0,1,2,...,NREQ-1,0,...
- rsp_ready high while not in DONE has no effect.

Optional Feature:
- Macro: SHIFT_OVERFLOW_EN.
- When defined:
  - Adds output rsp_overflow (1 bit, reset 0).
  - A sticky flag is cleared on accept. It is set in any SHIFT cycle where acc[WIDTH-1]==1 before the shift.
  - rsp_overflow is valid with rsp_valid and holds with it.
- When undefined: the port and its logic are absent, and all other behaviour is identical.

Decomposition:
- Package shift_arb_pkg holds:
  - the state enum (IDLE, SHIFT, DONE)
  - a default-width constant equal to 12
  - a function clamp_amount(amount, width) that returns min(amount, width)
- Sub-module rr_arbiter (NREQ parameter) holds:
  - inputs: req, last_grant, enable
  - outputs: one-hot grant and its index
  - purely combinational, with last_grant held in the parent

Test Plan:
- Req0 value=1, amount=1, rsp_ready=1 -> rsp_valid exactly 2 cycles after accept; rsp_value=2, rsp_id=0.
- Req0 value=0x5A5, amount=0 -> rsp_valid 1 cycle after accept; rsp_value=0x5A5.
- Req2 value=0xFFF, amount=4095 -> rsp_valid 13 cycles after accept; rsp_value=0; rsp_overflow=1 when SHIFT_OVERFLOW_EN is defined.
- All four requesters valid continuously, each value=1, amount=i+1 -> responses in id order 0,1,2,3,0 with values 2,4,8,16,2; at most one req_ready bit high in any cycle.
- Req1 value=3, amount=2, rsp_ready held low 5 cycles -> rsp_valid=1, rsp_value=12, rsp_id=1 stable for all 5 cycles; state returns to IDLE the cycle after rsp_ready rises; no accept in the handshake cycle.
- Req3 value=1, amount=8; reset asserted on the 4th SHIFT cycle -> all outputs 0 immediately; after release, req0 and req3 both valid -> req0 granted first.
